// File: rtl/direction_input_pkg.sv
// -----------------------------------------------------------------------------
// direction_input_pkg
//   Shared game definitions used by the input front end and the snake core:
//   direction encoding, the reversal test, the seed reset value and the seed
//   shift step.
// -----------------------------------------------------------------------------
package direction_input_pkg;

    // Direction encoding. Opposite pairs differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Seed reset value. Also substituted whenever a seed update would yield 0.
    localparam logic [15:0] SEED_INIT = 16'hACE1;

    // True when a and b point in opposite directions (up/down or left/right).
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // One left-shift step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
    function automatic logic [15:0] seed_shift(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/direction_input_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   One raw push button to a clean, polarity-normalized level.
//   Chain: 2-FF synchronizer -> polarity XOR -> run-length debounce counter.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip level (>= 2)
//   ACTIVE_LOW       1: the raw pin reads 0 while the button is pressed
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   raw    raw button pin, asynchronous to clk
//   level  debounced level, 1 = pressed
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             sample;
    logic [CNT_W-1:0] cnt;

    // The synchronizer resets to the released pin level so that releasing
    // reset never looks like a press.
    // NOTE: every clocked register here uses non-blocking (<=) assignments so
    // that all flops sample their inputs from the same clock edge; blocking
    // assignments would let sync_b see the new sync_a in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= ACTIVE_LOW;
            sync_b <= ACTIVE_LOW;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Normalize polarity: 1 always means pressed from here on.
    assign sample = sync_b ^ ACTIVE_LOW;

    // Count consecutive samples that disagree with the current level; any
    // agreeing sample restarts the run, so short glitches are absorbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sample == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/direction_input.sv
// -----------------------------------------------------------------------------
// direction_input
//   Input front end for the snake game. Four raw arrow buttons become a
//   legal, step-aligned direction command, and press timing stirs a
//   never-zero random seed for the apple generator.
//
// Parameters
//   DEBOUNCE_CYCLES  debounce run length per button (>= 2)
//   ACTIVE_LOW_MASK  per-button polarity, bit0 up .. bit3 right; 1 = pressed low
//   SEED_INIT        seed reset value and zero-substitute
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   arrow_up     raw up button
//   arrow_down   raw down button
//   arrow_left   raw left button
//   arrow_right  raw right button
//   step         one-cycle game tick; commits the pending request
//   clear        synchronous restart of dire/arrow_req to up
//   dire         committed direction (0 up, 1 down, 2 left, 3 right)
//   arrow_req    pending accepted request
//   press_pulse  one-cycle pulse per accepted press
//   pressed      debounced, polarity-normalized button levels
//   seed         16-bit random seed, never 0
// -----------------------------------------------------------------------------
module direction_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter logic [3:0]  ACTIVE_LOW_MASK = 4'b0011,
    parameter logic [15:0] SEED_INIT       = direction_input_pkg::SEED_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arrow_up,
    input  logic        arrow_down,
    input  logic        arrow_left,
    input  logic        arrow_right,
    input  logic        step,
    input  logic        clear,
    output logic [1:0]  dire,
    output logic [1:0]  arrow_req,
    output logic        press_pulse,
    output logic [3:0]  pressed,
    output logic [15:0] seed
);

    import direction_input_pkg::*;

    logic [3:0]  raw;
    logic [3:0]  pressed_d;
    logic [3:0]  rise;
    logic        any_rise;
    dir_t        cand;
    dir_t        dire_q;
    dir_t        req_q;
    dir_t        dire_next;
    logic        accept;
    logic [15:0] free_cnt;
    logic [15:0] seed_mix;
    logic [15:0] seed_new;

    assign raw = {arrow_right, arrow_left, arrow_down, arrow_up};

    // -------------------------------------------------------------------------
    // Per-button synchronizer + debounce
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[k])
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[k]),
            .level (pressed[k])
        );
    end

    // Press events are 0->1 transitions of the debounced level; releases are
    // ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed_d <= '0;
        end else begin
            pressed_d <= pressed;
        end
    end

    assign rise     = pressed & ~pressed_d;
    assign any_rise = |rise;

    // -------------------------------------------------------------------------
    // Candidate selection, reversal filter and seed mixing
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cand = DIR_UP;
        if      (rise[0]) cand = DIR_UP;
        else if (rise[1]) cand = DIR_DOWN;
        else if (rise[2]) cand = DIR_LEFT;
        else if (rise[3]) cand = DIR_RIGHT;

        // The reversal test looks at where the snake will be heading after
        // this cycle, so a same-cycle step makes arrow_req the reference.
        dire_next = step ? req_q : dire_q;

        accept = any_rise && !clear && !is_opposite(cand, dire_next);

        seed_mix = seed_shift(seed) ^ free_cnt;
        seed_new = (seed_mix == 16'd0) ? SEED_INIT : seed_mix;
    end

    // -------------------------------------------------------------------------
    // Direction state
    // -------------------------------------------------------------------------
    // clear wins over both step and an accepted press (accept already excludes
    // clear). step commits the pre-update arrow_req, so a request accepted in
    // the same cycle waits for the next step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dire_q      <= DIR_UP;
            req_q       <= DIR_UP;
            press_pulse <= 1'b0;
        end else if (clear) begin
            dire_q      <= DIR_UP;
            req_q       <= DIR_UP;
            press_pulse <= 1'b0;
        end else begin
            if (step) begin
                dire_q <= req_q;
            end
            if (accept) begin
                req_q <= cand;
            end
            press_pulse <= accept;
        end
    end

    assign dire      = dire_q;
    assign arrow_req = req_q;

    // -------------------------------------------------------------------------
    // Random seed
    // -------------------------------------------------------------------------
    // The free-running counter makes the seed depend on exactly when presses
    // land, which is the only entropy source available.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_cnt <= '0;
            seed     <= SEED_INIT;
        end else begin
            free_cnt <= free_cnt + 16'd1;
            if (accept) begin
                seed <= seed_new;
            end
        end
    end

endmodule

// File: tb/tb_direction_input.sv
// -----------------------------------------------------------------------------
// tb_direction_input
//   Self-checking bench for direction_input with DEBOUNCE_CYCLES = 4.
//   A scoreboard queue holds the arrow_req expected at each press_pulse; a
//   monitor pops it on every pulse and also tracks the expected seed.
// -----------------------------------------------------------------------------
module tb_direction_input;

    localparam int unsigned DEB  = 4;
    localparam logic [3:0]  MASK = 4'b0011;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_raw;
    logic        step;
    logic        clear;
    logic [1:0]  dire;
    logic [1:0]  arrow_req;
    logic        press_pulse;
    logic [3:0]  pressed;
    logic [15:0] seed;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt = 0;

    logic [1:0]  sb_q[$];
    logic [15:0] model_cnt;
    logic [15:0] model_seed = SEED;

    typedef struct {
        int         btn;
        bit         do_step;
        bit         accept;
        logic [1:0] exp_req;
        logic [1:0] exp_dire;
    } vec_t;

    always #5 clk = ~clk;

    direction_input #(
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW_MASK (MASK),
        .SEED_INIT       (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arrow_up    (btn_raw[0]),
        .arrow_down  (btn_raw[1]),
        .arrow_left  (btn_raw[2]),
        .arrow_right (btn_raw[3]),
        .step        (step),
        .clear       (clear),
        .dire        (dire),
        .arrow_req   (arrow_req),
        .press_pulse (press_pulse),
        .pressed     (pressed),
        .seed        (seed)
    );

    // Reference free-running counter: cleared by reset, +1 every clock.
    always @(posedge clk or posedge reset) begin
        if (reset) model_cnt <= '0;
        else       model_cnt <= model_cnt + 16'd1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int k, input logic prs);
        btn_raw[k] = prs ^ MASK[k];
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Press, hold long enough to debounce and accept, then release and settle.
    task automatic press_release(input int k);
        set_btn(k, 1'b1);
        tick(12);
        set_btn(k, 1'b0);
        tick(10);
    endtask

    // Scoreboard monitor: every press_pulse must match a queued expectation.
    always @(negedge clk) begin
        logic [15:0] nxt;
        if (reset) begin
            model_seed = SEED;
        end else if (press_pulse) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                check("press_pulse with empty scoreboard", 32'(press_pulse), 32'd0);
            end else begin
                check("arrow_req at press_pulse", 32'(arrow_req), 32'(sb_q.pop_front()));
            end
            nxt = lfsr_step(model_seed) ^ (model_cnt - 16'd1);
            model_seed = (nxt == 16'd0) ? SEED : nxt;
            check("seed after press", 32'(seed), 32'(model_seed));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          seen;
        int          p0;
        int          n;
        logic [15:0] target;

        // Start of the table run: dire = 0, arrow_req = 0.
        vecs[0] = '{2, 1'b1, 1'b1, 2'd2, 2'd2};  // left, step -> commit left
        vecs[1] = '{3, 1'b1, 1'b0, 2'd2, 2'd2};  // right vs left: reversal
        vecs[2] = '{0, 1'b0, 1'b1, 2'd0, 2'd2};  // up accepted, not committed
        vecs[3] = '{1, 1'b1, 1'b1, 2'd1, 2'd1};  // down overrides up, commit
        vecs[4] = '{0, 1'b1, 1'b0, 2'd1, 2'd1};  // up vs down: reversal
        vecs[5] = '{3, 1'b1, 1'b1, 2'd3, 2'd3};  // right
        vecs[6] = '{3, 1'b1, 1'b1, 2'd3, 2'd3};  // same as current: accepted
        vecs[7] = '{2, 1'b0, 1'b0, 2'd3, 2'd3};  // left vs right: reversal

        btn_raw = MASK;
        step    = 1'b0;
        clear   = 1'b0;
        reset   = 1'b1;
        tick(3);

        // ---- Reset values --------------------------------------------------
        check("reset dire", 32'(dire), 32'd0);
        check("reset arrow_req", 32'(arrow_req), 32'd0);
        check("reset press_pulse", 32'(press_pulse), 32'd0);
        check("reset pressed", 32'(pressed), 32'd0);
        check("reset seed", 32'(seed), 32'(SEED));
        reset = 1'b0;
        tick(50);
        check("idle dire", 32'(dire), 32'd0);
        check("idle arrow_req", 32'(arrow_req), 32'd0);
        check("idle pressed", 32'(pressed), 32'd0);
        check("idle seed", 32'(seed), 32'(SEED));
        check("idle press_pulse count", 32'(pulse_cnt), 32'd0);

        // ---- Right: latency, accept, commit ---------------------------------
        sb_q.push_back(2'd3);
        set_btn(3, 1'b1);
        lat = 0;
        while (!pressed[3] && lat < 20) begin
            tick(1);
            lat++;
        end
        check("right debounce latency", 32'(lat), 32'd6);
        tick(14);
        check("right arrow_req", 32'(arrow_req), 32'd3);
        check("right dire before step", 32'(dire), 32'd0);
        pulse_step();
        check("right dire after step", 32'(dire), 32'd3);
        set_btn(3, 1'b0);
        tick(10);
        check("right scoreboard drained", 32'(sb_q.size()), 32'd0);

        pulse_clear();
        check("clear dire", 32'(dire), 32'd0);
        check("clear arrow_req", 32'(arrow_req), 32'd0);

        // ---- Table-driven press sequence ------------------------------------
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].accept) sb_q.push_back(vecs[i].exp_req);
            press_release(vecs[i].btn);
            if (vecs[i].do_step) pulse_step();
            check($sformatf("vec%0d arrow_req", i), 32'(arrow_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d dire", i), 32'(dire), 32'(vecs[i].exp_dire));
        end
        check("table scoreboard drained", 32'(sb_q.size()), 32'd0);

        // ---- Down while heading up is rejected; short glitch is absorbed ----
        pulse_clear();
        set_btn(1, 1'b1);
        tick(15);
        check("down debounced level", 32'(pressed), 32'b0010);
        check("down rejected arrow_req", 32'(arrow_req), 32'd0);
        set_btn(1, 1'b0);
        tick(10);
        seen = 0;
        set_btn(2, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i == 3) set_btn(2, 1'b0);
            tick(1);
            if (pressed[2]) seen++;
        end
        check("3-cycle glitch pressed[2]", 32'(seen), 32'd0);

        // ---- Right press event coincides with step while req = left ---------
        pulse_clear();
        sb_q.push_back(2'd2);
        press_release(2);
        check("pre-step arrow_req", 32'(arrow_req), 32'd2);
        check("pre-step dire", 32'(dire), 32'd0);
        set_btn(3, 1'b1);
        tick(6);
        check("right event cycle pressed", 32'(pressed[3]), 32'd1);
        pulse_step();
        check("coincident step dire", 32'(dire), 32'd2);
        check("coincident step arrow_req", 32'(arrow_req), 32'd2);
        tick(5);
        set_btn(3, 1'b0);
        tick(10);
        check("coincident scoreboard drained", 32'(sb_q.size()), 32'd0);

        // ---- Up and left rise together while heading right ------------------
        pulse_clear();
        sb_q.push_back(2'd3);
        press_release(3);
        pulse_step();
        check("heading right dire", 32'(dire), 32'd3);
        p0 = pulse_cnt;
        sb_q.push_back(2'd0);
        set_btn(0, 1'b1);
        set_btn(2, 1'b1);
        tick(12);
        check("simultaneous pressed", 32'(pressed), 32'b0101);
        check("simultaneous arrow_req", 32'(arrow_req), 32'd0);
        set_btn(0, 1'b0);
        set_btn(2, 1'b0);
        tick(10);
        check("simultaneous pulse count", 32'(pulse_cnt - p0), 32'd1);
        check("simultaneous dire", 32'(dire), 32'd3);

        // ---- Reset while a button is mid-debounce ---------------------------
        set_btn(3, 1'b1);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("mid-debounce reset pressed", 32'(pressed), 32'd0);
        sb_q.push_back(2'd3);
        reset = 1'b0;
        lat = 0;
        while (!pressed[3] && lat < 20) begin
            tick(1);
            lat++;
        end
        check("post-reset latency", 32'(lat), 32'd6);
        tick(8);
        set_btn(3, 1'b0);
        tick(10);
        check("post-reset scoreboard drained", 32'(sb_q.size()), 32'd0);

        // ---- Force seed mix to zero -----------------------------------------
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        // Up is driven when the counter is 6 below the value it will hold at
        // the accept edge (2 sync + 4 debounce cycles, then the accept edge).
        target = lfsr_step(SEED) - 16'd6;
        n = 0;
        while (model_cnt != target && n < 70000) begin
            tick(1);
            n++;
        end
        check("seed-zero alignment reached", 32'(model_cnt), 32'(target));
        sb_q.push_back(2'd0);
        set_btn(0, 1'b1);
        tick(12);
        check("seed-zero substitute", 32'(seed), 32'(SEED));
        set_btn(0, 1'b0);
        tick(10);

        // ---- clear discards a same-cycle candidate --------------------------
        set_btn(2, 1'b1);
        tick(6);
        pulse_clear();
        check("clear discards candidate", 32'(arrow_req), 32'd0);
        tick(5);
        set_btn(2, 1'b0);
        tick(10);

        // ---- clear together with step ---------------------------------------
        sb_q.push_back(2'd3);
        press_release(3);
        check("pre-clear arrow_req", 32'(arrow_req), 32'd3);
        step  = 1'b1;
        clear = 1'b1;
        tick(1);
        step  = 1'b0;
        clear = 1'b0;
        check("clear+step dire", 32'(dire), 32'd0);
        check("clear+step arrow_req", 32'(arrow_req), 32'd0);
        check("clear keeps seed", 32'(seed), 32'(model_seed));
        tick(5);
        check("final scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
